imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction ROM/RAM that the fetch path (PC, +4 adder, instruction memory, decoder) reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to instruction memory at word-aligned byte addresses 0x00, 0x04, 0x08, ...
- Holds the core in reset (cpu_hold) until a complete image has loaded.

Parameters:
- ADDR_W, 8, byte-address width of instruction memory; matches the PC width.
- MAX_WORDS, 64, capacity in 32-bit words; MAX_WORDS*4 must not exceed 2^ADDR_W.
- CNT_W, $clog2(MAX_WORDS+1), width of word_count (7 at default).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  input  1  byte present on in_data.
- in_ready  output  1  loader can accept a byte this cycle.
- in_data  input  8  stream byte.
- in_last  input  1  qualifies the final byte of the image; sampled with in_valid.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_W  byte address, word aligned.
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  high means the core PC/fetch is held in reset.
- busy  output  1  load in progress.
- done  output  1  image loaded successfully.
- error  output  1  load aborted (partial word or overflow).
- word_count  output  CNT_W  words written in the current or last load.
- checksum  output  32  XOR of all words written in the current or last load.

Behaviour:
- A byte is accepted when in_valid and in_ready are both high on a rising edge.
- Reset (rst=0, asynchronous): state=IDLE, cpu_hold=1; every other output 0, including internal byte index and assembly register.
- Registered outputs: all outputs are registered except in_ready, which is decoded from state.
- IDLE:
  - in_ready=0, busy=0.
  - start -> COLLECT; clears word_count, checksum, byte index, done and error.
- COLLECT:
  - in_ready=1, busy=1.
  - Accepted byte goes into lane byte_idx; first byte -> bits[7:0], fourth -> bits[31:24].
  - byte_idx==3 -> WRITE; in_last is latched into last_f.
  - byte_idx<3 with in_last=1 -> ERROR (partial word); no write.
  - Otherwise byte_idx increments and the state stays COLLECT.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1.
  - mem_addr = word_count*4, truncated to ADDR_W; mem_wdata = assembled word.
  - checksum ^= word; word_count += 1; byte_idx -> 0.
  - Next state: last_f -> DONE; else if the new word_count == MAX_WORDS -> ERROR (overflow); else COLLECT.
- DONE:
  - done=1, cpu_hold=0, busy=0, in_ready=0.
  - start -> COLLECT (reload): cpu_hold=1, done=0, counters cleared.
- ERROR:
  - error=1, cpu_hold=1, busy=0, in_ready=0.
  - start -> COLLECT, which clears error.
- Latency: the write strobe occurs in the cycle after the 4th byte of a word is accepted. Peak throughput is 4 bytes per 5 cycles.
- start while busy (COLLECT/WRITE) is ignored.
- in_valid outside COLLECT: no effect; the byte is not consumed and the source must hold it.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset mid-load: immediate return to IDLE with cpu_hold=1. Memory words already written are left as is; no further writes occur.
- Exactly MAX_WORDS words with in_last on the final byte -> DONE, not ERROR.

Test Plan:
1. Reset: assert rst=0 mid-cycle -> asynchronously cpu_hold=1; mem_we, in_ready, busy, done, error, word_count and checksum all 0. Release; with no start, state stays idle and in_ready=0.
2. Two-word load: start, then bytes 13 00 00 00 93 00 10 00 with in_last on the 8th byte. Required response:
   - write addr 0x00, data 0x00000013;
   - write addr 0x04, data 0x00100093;
   - then done=1, cpu_hold=0, word_count=2, checksum=0x00100080.
3. Backpressure: random in_valid gaps; source holds a byte while in_ready=0 in the WRITE cycle; start pulsed mid-load. Required: identical writes to scenario 2, no byte lost or duplicated, start ignored.
4. Partial word: start, bytes AA BB CC with in_last on CC -> error=1, no mem_we ever asserted, cpu_hold=1, done=0, word_count=0.
5. Capacity:
   - 256 bytes without in_last -> 64 writes at addr 0x00..0xFC, then error=1 and in_ready=0.
   - Repeat with in_last on byte 256 -> done=1, error=0, word_count=64.
6. Reset mid-load and reload: reset after 5 accepted bytes -> IDLE immediately with cpu_hold=1. New start plus scenario 2 stream -> writes begin again at addr 0x00 and complete with done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: packs little-endian bytes into 32-bit
// words, writes them at consecutive word addresses and holds the core until done.
//   state   | meaning
//   IDLE    | waiting for start, core held
//   COLLECT | accepting bytes of the current word
//   WRITE   | one-cycle write strobe of the assembled word
//   DONE    | image complete, core released
//   ERROR   | partial word or overflow, core held
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  word_count,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;
    logic              r_last_f;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [CNT_W-1:0]  r_word_count;
    logic [31:0]       r_checksum;

    logic              w_accept;
    logic              w_start_load;
    logic [CNT_W-1:0]  w_count_inc;

    assign in_ready    = (r_state == S_COLLECT);
    assign w_accept    = in_valid && in_ready;
    assign w_count_inc = r_word_count + CNT_W'(1);

    always_comb begin
        w_next       = r_state;
        w_start_load = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_next       = S_COLLECT;
                    w_start_load = 1'b1;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    if (r_byte_idx == 2'd3)
                        w_next = S_WRITE;
                    else if (in_last)
                        w_next = S_ERROR;
                end
            end
            S_WRITE: begin
                // in_last on the final word wins over the capacity limit
                if (r_last_f)
                    w_next = S_DONE;
                else if (w_count_inc == CNT_W'(MAX_WORDS))
                    w_next = S_ERROR;
                else
                    w_next = S_COLLECT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_last_f     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_checksum   <= 32'd0;
        end else begin
            r_state    <= w_next;
            r_mem_we   <= (w_next == S_WRITE);
            r_busy     <= (w_next == S_COLLECT) || (w_next == S_WRITE);
            r_done     <= (w_next == S_DONE);
            r_error    <= (w_next == S_ERROR);
            r_cpu_hold <= (w_next != S_DONE);

            if (w_start_load) begin
                r_word_count <= '0;
                r_checksum   <= 32'd0;
                r_byte_idx   <= 2'd0;
                r_last_f     <= 1'b0;
            end

            if (w_accept) begin
                if (r_byte_idx == 2'd3) begin
                    r_mem_wdata <= {in_data, r_word};
                    r_mem_addr  <= ADDR_W'({r_word_count, 2'b00});
                    r_last_f    <= in_last;
                end else begin
                    r_word[{r_byte_idx, 3'b000} +: 8] <= in_data;
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end

            if (r_state == S_WRITE) begin
                r_word_count <= w_count_inc;
                r_checksum   <= r_checksum ^ r_mem_wdata;
                r_byte_idx   <= 2'd0;
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign word_count = r_word_count;
    assign checksum   = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes and final status
// come from a word-level model of the byte stream.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  word_count;
    logic [31:0]       checksum;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  stim_d[$];
    bit          stim_l[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_w[$];
    logic [31:0] obs_a[$];
    logic [31:0] obs_w[$];

    always @(negedge clk) begin
        if (mem_we) begin
            obs_a.push_back(32'(mem_addr));
            obs_w.push_back(mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Word-level view of the stream: every 4 bytes form a word at the next address.
    task automatic model(output bit e_done, output bit e_err, output int nw, output logic [31:0] cs);
        logic [31:0] w;
        exp_a.delete();
        exp_w.delete();
        e_done = 0; e_err = 0; nw = 0; cs = 0; w = 0;
        for (int i = 0; i < stim_d.size(); i++) begin
            w[8*(i%4) +: 8] = stim_d[i];
            if (i % 4 == 3) begin
                exp_a.push_back(32'((nw * 4) % (1 << ADDR_W)));
                exp_w.push_back(w);
                cs ^= w;
                nw++;
                if (stim_l[i]) begin e_done = 1; break; end
                if (nw == MAX_WORDS) begin e_err = 1; break; end
            end else if (stim_l[i]) begin
                e_err = 1;
                break;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; sends n bytes, optional random gaps and a stray start pulse.
    task automatic drive_bytes(input int n, input int gap_pct, input int start_at);
        int t;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stim_d[i];
            in_last  = stim_l[i];
            start    = (i == start_at);
            t = 0;
            while (!in_ready && t < 50) begin
                @(negedge clk);
                start = 1'b0;
                t++;
            end
            if (t >= 50) begin
                check_eq("accept_timeout", 32'(t), 32'd0);
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("end_reached", 32'(done || error), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_nwrites"}, 32'(obs_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), obs_a[i], exp_a[i]);
            check_eq($sformatf("%s_data%0d", tag, i), obs_w[i], exp_w[i]);
        end
    endtask

    task automatic run_load(input string tag, input int gap_pct, input int start_at);
        bit          ed, ee;
        int          nw;
        logic [31:0] cs;
        model(ed, ee, nw, cs);
        obs_a.delete();
        obs_w.delete();
        do_start();
        drive_bytes(stim_d.size(), gap_pct, start_at);
        wait_end();
        repeat (2) @(negedge clk);
        check_writes(tag);
        check_eq({tag, "_done"},     32'(done),       32'(ed));
        check_eq({tag, "_error"},    32'(error),      32'(ee));
        check_eq({tag, "_cpu_hold"}, 32'(cpu_hold),   32'(!ed));
        check_eq({tag, "_busy"},     32'(busy),       32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready),   32'd0);
        check_eq({tag, "_count"},    32'(word_count), 32'(nw));
        check_eq({tag, "_checksum"}, checksum,        cs);
    endtask

    task automatic load_two_word();
        logic [7:0] b[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < 8; i++) begin
            stim_d.push_back(b[i]);
            stim_l.push_back(i == 7);
        end
    endtask

    task automatic load_random(input int nbytes, input bit with_last);
        stim_d.delete();
        stim_l.delete();
        for (int i = 0; i < nbytes; i++) begin
            stim_d.push_back(8'($urandom));
            stim_l.push_back(with_last && (i == nbytes - 1));
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_cpu_hold", 32'(cpu_hold),   32'd1);
        check_eq("rst_mem_we",   32'(mem_we),     32'd0);
        check_eq("rst_in_ready", 32'(in_ready),   32'd0);
        check_eq("rst_busy",     32'(busy),       32'd0);
        check_eq("rst_done",     32'(done),       32'd0);
        check_eq("rst_error",    32'(error),      32'd0);
        check_eq("rst_count",    32'(word_count), 32'd0);
        check_eq("rst_checksum", checksum,        32'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_in_ready", 32'(in_ready), 32'd0);
        check_eq("idle_busy",     32'(busy),     32'd0);
        check_eq("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        in_valid = 1'b0;

        // two-word image
        load_two_word();
        run_load("two_word", 0, -1);
        check_eq("two_word_csum_const", checksum,  32'h00100080);
        check_eq("two_word_last_data",  mem_wdata, 32'h00100093);

        // backpressure with a stray start
        run_load("backpressure", 40, 5);

        // partial word
        stim_d.delete();
        stim_l.delete();
        stim_d = '{8'hAA, 8'hBB, 8'hCC};
        stim_l = '{1'b0, 1'b0, 1'b1};
        run_load("partial", 0, -1);

        // capacity: overflow, then exactly full with in_last
        load_random(MAX_WORDS * 4, 1'b0);
        run_load("overflow", 10, -1);
        load_random(MAX_WORDS * 4, 1'b1);
        run_load("full", 10, -1);

        // randomized loads, some ending on a partial word
        for (int k = 0; k < 8; k++) begin
            int nb = 4 * $urandom_range(1, 8);
            if (k % 3 == 2) nb += $urandom_range(1, 3);
            load_random(nb, 1'b1);
            run_load($sformatf("rand%0d", k), $urandom_range(0, 50), $urandom_range(1, nb - 1));
        end

        // reset after five accepted bytes, then reload
        load_two_word();
        obs_a.delete();
        obs_w.delete();
        do_start();
        drive_bytes(5, 0, -1);
        check_eq("midrst_writes_before", 32'(obs_a.size()), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_cpu_hold", 32'(cpu_hold),   32'd1);
        check_eq("midrst_busy",     32'(busy),       32'd0);
        check_eq("midrst_in_ready", 32'(in_ready),   32'd0);
        check_eq("midrst_count",    32'(word_count), 32'd0);
        obs_a.delete();
        obs_w.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_no_writes", 32'(obs_a.size()), 32'd0);
        run_load("reload", 20, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
